// File: rtl/alu_pkg.sv
// Shared ALU definitions: func codes, NZCV flag bit positions and the issue FSM state type.
package alu_pkg;

  localparam logic [2:0] RADD = 3'd0;
  localparam logic [2:0] RSUB = 3'd1;
  localparam logic [2:0] RMUL = 3'd2;
  localparam logic [2:0] RAND = 3'd3;
  localparam logic [2:0] ROR  = 3'd4;
  localparam logic [2:0] RXOR = 3'd5;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    MULW = 2'd2,
    HOLD = 2'd3
  } state_t;

endpackage

// File: rtl/alu_issue.sv
// Issues one operation at a time to an external ALU and holds the captured result.
// Define ALU_ISSUE_MUL_EN to give RMUL an extra MULW cycle for the multiplier path.
module alu_issue
  import alu_pkg::*;
#(
  parameter int n = 8
) (
  input  logic         clock,
  input  logic         nreset,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic [n-1:0] req_a,
  input  logic [n-1:0] req_b,
  input  logic [2:0]   req_func,
  output logic [n-1:0] a,
  output logic [n-1:0] b,
  output logic [2:0]   func,
  input  logic [n-1:0] out,
  input  logic [3:0]   flags,
  output logic         res_valid,
  input  logic         res_ready,
  output logic [n-1:0] res_data,
  output logic [3:0]   res_flags,
  output logic [3:0]   status_flags,
  output state_t       dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are both 1;
  // valid never waits on ready, and ready is only ever high in IDLE (requests) or HOLD (results).
  state_t state, state_nxt;
  logic   accept;
  logic   capture;

  assign req_ready = (state == IDLE) && nreset;
  assign res_valid = (state == HOLD);
  assign dbg_state = state;

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    capture   = 1'b0;
    case (state)
      IDLE: begin
        if (req_valid) begin
          accept = 1'b1;
`ifdef ALU_ISSUE_MUL_EN
          state_nxt = (req_func == RMUL) ? MULW : EXEC;
`else
          state_nxt = EXEC;
`endif
        end
      end
`ifdef ALU_ISSUE_MUL_EN
      MULW: state_nxt = EXEC;
`endif
      EXEC: begin
        capture   = 1'b1;
        state_nxt = HOLD;
      end
      HOLD: begin
        if (res_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!nreset) begin
      state        <= IDLE;
      a            <= '0;
      b            <= '0;
      func         <= RADD;
      res_data     <= '0;
      res_flags    <= '0;
      status_flags <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        a    <= req_a;
        b    <= req_b;
        func <= req_func;
      end
      if (capture) begin
`ifdef ALU_ISSUE_MUL_EN
        res_data     <= out;
        res_flags    <= flags;
        status_flags <= flags;
`else
        // Without a multiplier RMUL yields a zero result and leaves status untouched.
        if (func == RMUL) begin
          res_data  <= '0;
          res_flags <= '0;
        end else begin
          res_data     <= out;
          res_flags    <= flags;
          status_flags <= flags;
        end
`endif
      end
    end
  end

endmodule

// File: tb/tb_alu_issue.sv
// Bench for alu_issue: ALU stub, transaction-level reference model, per-cycle checker,
// directed literal cases and randomized traffic with occasional resets.
module tb_alu_issue;
  import alu_pkg::*;

  localparam int W = 8;
`ifdef ALU_ISSUE_MUL_EN
  localparam bit MUL_EN = 1'b1;
`else
  localparam bit MUL_EN = 1'b0;
`endif

  logic         clock = 1'b0;
  logic         nreset;
  logic         req_valid;
  logic         req_ready;
  logic [W-1:0] req_a, req_b;
  logic [2:0]   req_func;
  logic [W-1:0] a, b;
  logic [2:0]   func;
  logic [W-1:0] alu_out;
  logic [3:0]   alu_flags;
  logic         res_valid;
  logic         res_ready;
  logic [W-1:0] res_data;
  logic [3:0]   res_flags;
  logic [3:0]   status_flags;
  state_t       dbg_state;

  int vectors = 0;
  int miscompares = 0;
  bit started = 1'b0;

  alu_issue #(.n(W)) dut (
    .clock(clock), .nreset(nreset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_func(req_func),
    .a(a), .b(b), .func(func),
    .out(alu_out), .flags(alu_flags),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_flags(res_flags),
    .status_flags(status_flags), .dbg_state(dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clock = ~clock;

  // ---------------- ALU behaviour (environment) ----------------
  function automatic logic [11:0] alu_ref(input logic [7:0] x, input logic [7:0] y,
                                          input logic [2:0] f);
    logic [8:0] s;
    logic [7:0] r;
    logic       c, v;
    s = '0; r = '0; c = 1'b0; v = 1'b0;
    case (f)
      RADD: begin
        s = {1'b0, x} + {1'b0, y};
        r = s[7:0];
        c = s[8];
        v = (x[7] == y[7]) && (r[7] != x[7]);
      end
      RSUB: begin
        r = x - y;
        c = (x >= y);
        v = (x[7] != y[7]) && (r[7] != x[7]);
      end
      RMUL: r = x * y;
      RAND: r = x & y;
      ROR:  r = x | y;
      RXOR: r = x ^ y;
      default: r = x ^ {y[3:0], y[7:4]};
    endcase
    return {r[7], (r == 8'h00), c, v, r};
  endfunction

  function automatic logic [11:0] expected(input logic [7:0] x, input logic [7:0] y,
                                           input logic [2:0] f);
    if (f == RMUL && !MUL_EN) return 12'h000;
    return alu_ref(x, y, f);
  endfunction

  assign {alu_flags, alu_out} = alu_ref(a, b, func);

  // ---------------- reference model ----------------
  logic [11:0]  exp_q[$];
  bit           m_busy = 1'b0;
  bit           m_has = 1'b0;
  int           m_wait = 0;
  logic [W-1:0] m_a = '0, m_b = '0;
  logic [2:0]   m_func = RADD;
  logic [W-1:0] m_data = '0;
  logic [3:0]   m_flags = '0;
  logic [3:0]   m_status = '0;

  task automatic model_step();
    if (!nreset) begin
      m_busy = 1'b0; m_has = 1'b0; m_wait = 0;
      m_a = '0; m_b = '0; m_func = RADD;
      m_data = '0; m_flags = '0; m_status = '0;
      exp_q.delete();
    end else if (m_has) begin
      if (res_ready) m_has = 1'b0;
    end else if (m_busy) begin
      m_wait--;
      if (m_wait == 0) begin
        m_busy = 1'b0;
        m_has  = 1'b1;
        if (exp_q.size() > 0) {m_flags, m_data} = exp_q.pop_front();
        if (!(m_func == RMUL && !MUL_EN)) m_status = m_flags;
      end
    end else if (req_valid) begin
      m_busy = 1'b1;
      m_wait = (req_func == RMUL && MUL_EN) ? 2 : 1;
      m_a = req_a; m_b = req_b; m_func = req_func;
      exp_q.push_back(expected(req_a, req_b, req_func));
    end
  endtask

  initial forever begin
    @(posedge clock);
    model_step();
    started = 1'b1;
  end

  // ---------------- scoreboard / checker ----------------
  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  initial forever begin
    @(negedge clock);
    if (started) begin
      check("req_ready", 16'(req_ready), 16'(nreset && !m_busy && !m_has));
      check("res_valid", 16'(res_valid), 16'(m_has));
      check("status_flags", 16'(status_flags), 16'(m_status));
      check("a", 16'(a), 16'(m_a));
      check("b", 16'(b), 16'(m_b));
      check("func", 16'(func), 16'(m_func));
      if (m_has) begin
        check("res_data", 16'(res_data), 16'(m_data));
        check("res_flags", 16'(res_flags), 16'(m_flags));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic issue(input logic [7:0] ia, input logic [7:0] ib, input logic [2:0] f);
    check("ready_before_issue", 16'(req_ready), 16'h1);
    req_a = ia; req_b = ib; req_func = f;
    req_valid = 1'b1;
    step();
    req_valid = 1'b0;
  endtask

  task automatic wait_res(output int lat);
    lat = 1;
    while (!res_valid && lat < 12) begin
      step();
      lat++;
    end
  endtask

  task automatic release_res();
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
  endtask

  task automatic do_op(input string tag, input logic [7:0] ia, input logic [7:0] ib,
                       input logic [2:0] f, input logic [7:0] ed, input logic [3:0] ef,
                       input int elat);
    int lat;
    issue(ia, ib, f);
    wait_res(lat);
    check({tag, "_latency"}, 16'(lat), 16'(elat));
    check({tag, "_data"}, 16'(res_data), 16'(ed));
    check({tag, "_flags"}, 16'(res_flags), 16'(ef));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int lat;
    nreset = 1'b0; req_valid = 1'b0; res_ready = 1'b0;
    req_a = '0; req_b = '0; req_func = RADD;
    step(); step();
    check("rst_req_ready", 16'(req_ready), 16'h0);
    check("rst_res_valid", 16'(res_valid), 16'h0);
    check("rst_res_data", 16'(res_data), 16'h0);
    check("rst_status", 16'(status_flags), 16'h0);
    check("rst_func", 16'(func), 16'(RADD));
    nreset = 1'b1;
    #1;
    check("ready_after_release", 16'(req_ready), 16'h1);

    // 1 + 3
    do_op("add", 8'h01, 8'h03, RADD, 8'h04, 4'b0000, 2);
    release_res();
    // 1 - 3 sets N, no carry
    do_op("sub", 8'h01, 8'h03, RSUB, 8'hFE, 4'b1000, 2);
    check("sub_status", 16'(status_flags), 16'(res_flags));
    release_res();
    // multiply: real result with the multiplier, zero and untouched status without
    do_op("mul", 8'h01, 8'h03, RMUL, MUL_EN ? 8'h03 : 8'h00, 4'b0000, MUL_EN ? 3 : 2);
    check("mul_status", 16'(status_flags), MUL_EN ? 16'h0 : 16'h8);
    release_res();
    // unassigned code passes through
    do_op("func7", 8'h5A, 8'h3C, 3'd7, 8'h5A ^ 8'hC3, 4'b1000, 2);
    release_res();

    // downstream stall with new requests knocking
    do_op("stall", 8'h22, 8'h11, RADD, 8'h33, 4'b0000, 2);
    for (int i = 0; i < 5; i++) begin
      req_valid = (i % 2 == 0);
      req_a = 8'($urandom); req_b = 8'($urandom); req_func = 3'($urandom_range(0, 7));
      step();
      check("stall_data", 16'(res_data), 16'h33);
      check("stall_ready", 16'(req_ready), 16'h0);
      check("stall_valid", 16'(res_valid), 16'h1);
    end
    req_valid = 1'b0;
    release_res();
    check("stall_release_ready", 16'(req_ready), 16'h1);
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall_no_extra", 16'(res_valid), 16'h0);
    end

    // reset while the multiply (or exec) is in flight
    issue(8'h01, 8'h03, RMUL);
    nreset = 1'b0;
    #1;
    check("abort1_ready_in_reset", 16'(req_ready), 16'h0);
    step();
    check("abort1_valid", 16'(res_valid), 16'h0);
    check("abort1_data", 16'(res_data), 16'h0);
    check("abort1_flags", 16'(res_flags), 16'h0);
    check("abort1_status", 16'(status_flags), 16'h0);
    check("abort1_a", 16'(a), 16'h0);
    check("abort1_b", 16'(b), 16'h0);
    nreset = 1'b1;
    #1;
    check("abort1_ready_release", 16'(req_ready), 16'h1);
    for (int i = 0; i < 4; i++) begin
      step();
      check("abort1_no_result", 16'(res_valid), 16'h0);
    end

    // reset while holding a result
    do_op("pre_abort2", 8'h80, 8'h80, RADD, 8'h00, 4'b0111, 2);
    nreset = 1'b0;
    step();
    check("abort2_valid", 16'(res_valid), 16'h0);
    check("abort2_data", 16'(res_data), 16'h0);
    check("abort2_status", 16'(status_flags), 16'h0);
    nreset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("abort2_no_result", 16'(res_valid), 16'h0);
    end

    // zero result, then status changes only at the next capture
    do_op("zero", 8'h00, 8'h00, RADD, 8'h00, 4'b0100, 2);
    check("zero_status", 16'(status_flags), 16'h4);
    release_res();
    issue(8'h05, 8'h03, RSUB);
    check("status_before_capture", 16'(status_flags), 16'h4);
    wait_res(lat);
    check("status_after_capture", 16'(status_flags), 16'h2);
    check("sub2_data", 16'(res_data), 16'h02);
    release_res();

    // randomized traffic
    for (int i = 0; i < 800; i++) begin
      req_valid = 1'($urandom_range(0, 1));
      req_a     = 8'($urandom);
      req_b     = 8'($urandom);
      req_func  = 3'($urandom_range(0, 7));
      res_ready = ($urandom_range(0, 3) != 0);
      nreset    = ($urandom_range(0, 59) != 0);
      step();
    end
    nreset = 1'b1; req_valid = 1'b0; res_ready = 1'b1;
    repeat (6) step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
